// File: rtl/calc_pkg.sv
// Shared definitions for the keypad calculator sequencer: key codes, ALU op codes,
// sequencer states and small key-classification helpers.
package calc_pkg;

    localparam int DIGITS = 4;
    localparam int W      = DIGITS * 4;

    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;

    localparam logic [3:0] KEY_PLUS  = 4'hA;
    localparam logic [3:0] KEY_MINUS = 4'hB;
    localparam logic [3:0] KEY_EQ    = 4'hC;
    localparam logic [3:0] KEY_CLR   = 4'hD;

    typedef enum logic [1:0] {
        ST_ENTER_A,
        ST_ENTER_B,
        ST_EVAL,
        ST_SHOW
    } state_t;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'd9;
    endfunction

    function automatic logic is_op_key(input logic [3:0] k);
        return (k == KEY_PLUS) || (k == KEY_MINUS);
    endfunction

    function automatic logic [1:0] key_to_op(input logic [3:0] k);
        return (k == KEY_MINUS) ? OP_SUB : OP_ADD;
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// BCD operand entry register: shifts in decimal digits up to a DIGITS-digit cap,
// with synchronous clear and a whole-value load (used for results and restarts).
module bcd_entry_reg
    import calc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load_digit,
    input  logic [3:0]   digit,
    input  logic         load_val,
    input  logic [W-1:0] val,
    input  logic [2:0]   val_cnt,
    output logic [W-1:0] value,
    output logic         full
);

    logic [2:0] cnt;

    assign full = (cnt == 3'(DIGITS));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            value <= '0;
            cnt   <= '0;
        end else if (load_val) begin
            value <= val;
            cnt   <= val_cnt;
        end else if (load_digit && !full) begin
            value <= {value[W-5:0], digit};
            cnt   <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Keypad sequencer for the BCD add/sub ALU: builds operands, runs one EVAL cycle on "=".
// Optional macro CALC_CHAIN_EN: +/- while entering B evaluates and chains the new operator.
module calc_seq_ctrl
    import calc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    input  logic [3:0]   key_code,
    output logic         key_ready,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic [W-1:0] alu_result,
    output logic [W-1:0] disp_bcd,
    output logic         op_pending,
    output logic         result_valid
);

    state_t         state_q, state_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   disp_q, disp_d;
    logic           rv_q, rv_d;
    logic           accept;
    logic           a_clr, a_ld, a_lv, b_clr, b_ld;
    logic [W-1:0]   a_val, a_value, b_value;
    logic [2:0]     a_vcnt;
    logic           a_full, b_full;
`ifdef CALC_CHAIN_EN
    logic           chain_q, chain_d;
    logic [1:0]     pend_q, pend_d;
`endif

    assign key_ready    = (state_q != ST_EVAL);
    assign accept       = key_valid && key_ready;
    assign alu_a        = a_value;
    assign alu_b        = b_value;
    assign alu_op       = op_q;
    assign disp_bcd     = disp_q;
    assign op_pending   = (state_q == ST_ENTER_B);
    assign result_valid = rv_q;

    bcd_entry_reg u_a (
        .clk(clk), .rst_n(rst_n), .clr(a_clr), .load_digit(a_ld), .digit(key_code),
        .load_val(a_lv), .val(a_val), .val_cnt(a_vcnt), .value(a_value), .full(a_full)
    );

    bcd_entry_reg u_b (
        .clk(clk), .rst_n(rst_n), .clr(b_clr), .load_digit(b_ld), .digit(key_code),
        .load_val(1'b0), .val('0), .val_cnt('0), .value(b_value), .full(b_full)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_ENTER_A;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ENTER_A: begin
                if (accept && is_op_key(key_code)) state_d = ST_ENTER_B;
            end
            ST_ENTER_B: begin
                if (accept) begin
                    if (key_code == KEY_CLR)     state_d = ST_ENTER_A;
                    else if (key_code == KEY_EQ) state_d = ST_EVAL;
`ifdef CALC_CHAIN_EN
                    else if (is_op_key(key_code)) state_d = ST_EVAL;
`endif
                end
            end
            ST_EVAL: begin
`ifdef CALC_CHAIN_EN
                state_d = chain_q ? ST_ENTER_B : ST_SHOW;
`else
                state_d = ST_SHOW;
`endif
            end
            ST_SHOW: begin
                if (accept) begin
                    if (is_digit(key_code) || key_code == KEY_CLR) state_d = ST_ENTER_A;
                    else if (is_op_key(key_code))                  state_d = ST_ENTER_B;
                    else if (key_code == KEY_EQ)                   state_d = ST_EVAL;
                end
            end
            default: state_d = ST_ENTER_A;
        endcase
    end

    always_comb begin
        a_clr  = 1'b0;
        a_ld   = 1'b0;
        a_lv   = 1'b0;
        a_val  = '0;
        a_vcnt = '0;
        b_clr  = 1'b0;
        b_ld   = 1'b0;
        op_d   = op_q;
        disp_d = disp_q;
        rv_d   = 1'b0;
`ifdef CALC_CHAIN_EN
        chain_d = chain_q;
        pend_d  = pend_q;
`endif
        if (accept && key_code == KEY_CLR) begin
            a_clr  = 1'b1;
            b_clr  = 1'b1;
            op_d   = OP_ADD;
            disp_d = '0;
`ifdef CALC_CHAIN_EN
            chain_d = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_ENTER_A: begin
                    if (accept && is_digit(key_code)) begin
                        a_ld = 1'b1;
                        if (!a_full) disp_d = {a_value[W-5:0], key_code};
                    end else if (accept && is_op_key(key_code)) begin
                        op_d  = key_to_op(key_code);
                        b_clr = 1'b1;
                    end
                end
                ST_ENTER_B: begin
                    if (accept && is_digit(key_code)) begin
                        b_ld = 1'b1;
                        if (!b_full) disp_d = {b_value[W-5:0], key_code};
                    end else if (accept && is_op_key(key_code)) begin
`ifdef CALC_CHAIN_EN
                        // Keep the pending op on the ALU during EVAL; swap at EVAL exit.
                        pend_d  = key_to_op(key_code);
                        chain_d = 1'b1;
`else
                        op_d = key_to_op(key_code);
`endif
                    end
                end
                ST_EVAL: begin
                    a_lv   = 1'b1;
                    a_val  = alu_result;
                    a_vcnt = 3'(DIGITS);
                    disp_d = alu_result;
                    rv_d   = 1'b1;
`ifdef CALC_CHAIN_EN
                    if (chain_q) begin
                        op_d    = pend_q;
                        b_clr   = 1'b1;
                        chain_d = 1'b0;
                    end
`endif
                end
                ST_SHOW: begin
                    if (accept && is_digit(key_code)) begin
                        a_lv   = 1'b1;
                        a_val  = {{(W-4){1'b0}}, key_code};
                        a_vcnt = 3'd1;
                        disp_d = {{(W-4){1'b0}}, key_code};
                    end else if (accept && is_op_key(key_code)) begin
                        op_d  = key_to_op(key_code);
                        b_clr = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= OP_ADD;
            disp_q  <= '0;
            rv_q    <= 1'b0;
`ifdef CALC_CHAIN_EN
            chain_q <= 1'b0;
            pend_q  <= OP_ADD;
`endif
        end else begin
            op_q    <= op_d;
            disp_q  <= disp_d;
            rv_q    <= rv_d;
`ifdef CALC_CHAIN_EN
            chain_q <= chain_d;
            pend_q  <= pend_d;
`endif
        end
    end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Keypad-driven sequencer for the 4-digit BCD saturating add/sub ALU. It accepts key events, builds operands A and B digit by digit, latches the operator, and on "=" drives the ALU for one evaluation cycle. It captures the result and holds it for the 7-segment display path. The block sits between the keypad decoder and the ALU/display mux.

Parameters:
DIGITS, 4, operand length in BCD digits; fixed at 4 to match the ALU width.
OP_ADD, 2'b01, ALU operation code for addition.
OP_SUB, 2'b10, ALU operation code for subtraction.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
key_valid  in  1  key event strobe; one event is accepted per cycle when key_ready=1
key_code  in  4  0-9 digit, A plus, B minus, C equals, D clear, E/F ignored
key_ready  out  1  block can accept a key event
alu_a  out  16  operand A in BCD, driven from a_reg
alu_b  out  16  operand B in BCD, driven from b_reg
alu_op  out  2  latched operator
alu_result  in  16  combinational BCD result from the ALU
disp_bcd  out  16  value to display
op_pending  out  1  high in ENTER_B (operator shown on LED)
result_valid  out  1  one-cycle pulse when a new result is latched

Behaviour:
- Reset (rst_n=0 at a clk edge): state=ENTER_A; a_reg=b_reg=0; cnt_a=cnt_b=0; op=OP_ADD; disp_bcd=0; key_ready=1; op_pending=0; result_valid=0. Reset has priority over everything, including a cycle in EVAL.
- A key is accepted when key_valid&key_ready. key_ready=0 only in EVAL. Codes E/F are accepted and discarded.
- All register updates from a key take effect at the next edge. disp_bcd is registered, so the display is 1-cycle latent from key acceptance.
- States: ENTER_A, ENTER_B, EVAL, SHOW.
- ENTER_A, digit d:
  - if cnt_a<4: a_reg<={a_reg[11:0],d}, cnt_a++, disp<=new a_reg.
  - if cnt_a=4: the digit is ignored (no wrap, no shift).
  - Leading zeros count as digits.
- ENTER_A, plus/minus: op<=code, b_reg<=0, cnt_b<=0, go to ENTER_B; disp keeps A.
- ENTER_A, equals: ignored.
- ENTER_B, digit: same entry rules applied to b_reg/cnt_b; disp shows B.
- ENTER_B, equals: go to EVAL.
- ENTER_B, plus/minus: see Optional Feature.
- EVAL (exactly one cycle): alu_a/alu_b/alu_op are stable from registers. At the exiting edge: a_reg<=alu_result, disp<=alu_result, cnt_a<=4, result_valid<=1 for the following cycle. Then go to SHOW, or to ENTER_B on a chained operator.
- SHOW, digit: a_reg<={12'h000,d}, cnt_a<=1, b_reg untouched, go to ENTER_A.
- SHOW, plus/minus: the result becomes A; op<=code, b_reg<=0, cnt_b<=0, go to ENTER_B.
- SHOW, equals: go to EVAL with the unchanged b_reg/op (repeat last operation).
- Clear in any accepting state: same values as reset.
- Saturation (0..9999) is performed by the ALU. The controller never modifies the result value.
- Operand registers only ever hold nibbles 0-9.
- Key timing: a key accepted at edge n puts the block in EVAL during cycle n+1. The result appears on disp_bcd and result_valid=1 during cycle n+2.

Optional Feature:
CALC_CHAIN_EN.
- Defined: plus/minus in ENTER_B evaluates the pending operation (EVAL). At EVAL exit: a_reg<=result, op<=new code, b_reg<=0, cnt_b<=0, go to ENTER_B; disp shows the intermediate result and result_valid pulses.
- Undefined: plus/minus in ENTER_B only replaces op; b_reg, disp and state are unchanged.

Decomposition:
- Package calc_pkg: key code constants (KEY_PLUS=4'hA … KEY_CLR=4'hD), OP_ADD/OP_SUB, state encoding (2-bit), is_digit helper function.
- One natural sub-module, bcd_entry_reg: 16-bit shift register with 3-bit digit counter, load-digit / clear / load-value controls, 4-digit cap. Instantiated for A and B.

Test Plan:
- Keys 1,2,3,4,+,5,= → disp 1234, then 0005; two cycles after "=", disp=1239 and result_valid=1 for exactly one cycle.
- Keys 9,9,9,9,+,1,= → alu_a=9999, alu_b=0001, alu_op=01; result 9999 (saturated).
- Keys 5,-,9,= → alu_op=10; disp 0000. Then "=" again → 0000. Then +,3,= → 0003.
- Keys 1,2,3,4,5 → disp 1234, cnt_a stays 4. Keys asserted while key_ready=0 in EVAL are not consumed and produce no state change.
- Keys 1,0,+,5,=,= → disp 0015 then 0020. Then digit 7 → disp 0007, state ENTER_A.
- Keys 2,+,3,+: with CALC_CHAIN_EN → disp 0005, op_pending=1. Without it → disp 0003, op=01. Separately, rst_n=0 during EVAL → all outputs return to reset values at that edge and result_valid stays 0.
